// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port async SRAM controller with one memory-mapped I/O word.
module sram_ctrl #(
   parameter int unsigned  WAIT_CYCLES = 2,
   parameter logic [19:0]  IO_ADDR     = 20'h0FFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req,
   input  logic        rw,
   input  logic [19:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ready,
   output logic        busy,
   input  logic [15:0] S,
   output logic [15:0] hex_out,
   output logic        CE,
   output logic        UB,
   output logic        LB,
   output logic        OE,
   output logic        WE,
   output logic [19:0] ADDR,
   inout  wire  [15:0] mdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        rw_q;
   logic [19:0] addr_q;
   logic [15:0] wdata_q;
   logic        drive;
   logic        is_io;
   logic        accept;

   assign is_io  = (addr == IO_ADDR);
   assign accept = (state == IDLE) && req;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = is_io ? DONE : ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are decoded from state so an asynchronous reset releases them at once.
   always_comb begin
      CE    = 1'b1;
      UB    = 1'b1;
      LB    = 1'b1;
      OE    = 1'b1;
      WE    = 1'b1;
      drive = 1'b0;
      ready = 1'b0;
      busy  = (state != IDLE);
      case (state)
         ACCESS: begin
            CE    = 1'b0;
            UB    = 1'b0;
            LB    = 1'b0;
            OE    = rw_q;
            WE    = ~rw_q;
            drive = rw_q;
         end
         DONE:    ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt     <= 4'd0;
         rw_q    <= 1'b0;
         addr_q  <= 20'd0;
         wdata_q <= 16'd0;
         rdata   <= 16'd0;
         hex_out <= 16'd0;
      end else begin
         if (accept) begin
            if (is_io) begin
               if (rw) hex_out <= wdata;
               else    rdata   <= S;
            end else begin
               rw_q    <= rw;
               addr_q  <= addr;
               wdata_q <= wdata;
               cnt     <= CNT_LOAD;
            end
         end
         if (state == ACCESS) begin
            if (cnt != 4'd0)  cnt   <= cnt - 4'd1;
            else if (!rw_q)   rdata <= mdata;
         end
      end
   end

   assign ADDR  = addr_q;
   assign mdata = drive ? wdata_q : 16'bz;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with an SRAM chip model.
module tb_sram_ctrl;

   localparam int          W  = 2;
   localparam logic [19:0] IO = 20'h0FFFF;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        req = 1'b0;
   logic        rw = 1'b0;
   logic [19:0] addr = 20'd0;
   logic [15:0] wdata = 16'd0;
   logic [15:0] S = 16'd0;
   wire  [15:0] mdata;
   logic [15:0] rdata;
   logic [15:0] hex_out;
   logic        ready, busy, CE, UB, LB, OE, WE;
   logic [19:0] ADDR;

   int checks = 0;
   int failures = 0;

   sram_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(IO)) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .busy(busy), .S(S), .hex_out(hex_out),
      .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .mdata(mdata)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] init_val(input logic [19:0] a);
      return {6'd0, a[9:0]} ^ 16'h5A5A;
   endfunction

   // SRAM chip: 1K words indexed by the low address bits.
   logic [15:0] chip [0:1023];
   assign mdata = (!CE && !OE && WE) ? chip[ADDR[9:0]] : 16'bz;
   always @(posedge Clk) if (!CE && !WE) chip[ADDR[9:0]] <= mdata;

   // Reference model: transfer-level view of memory, read result and display.
   logic [15:0] ref_mem [int];
   logic [15:0] ref_rdata;
   logic [15:0] ref_hex;

   function automatic logic [15:0] ref_read(input logic [19:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic r, input logic [19:0] a, input logic [15:0] d,
                       input logic [15:0] s, output int lat, output logic [15:0] rd,
                       output logic [15:0] hx, output int ce_n, output int we_n,
                       output int oe_n, output int bad);
      lat = 0; ce_n = 0; we_n = 0; oe_n = 0; bad = 0;
      rd = 16'hxxxx; hx = 16'hxxxx;
      req = 1'b1; rw = r; addr = a; wdata = d; S = s;
      @(posedge Clk);
      @(negedge Clk);
      req = 1'b0; rw = 1'($urandom); addr = 20'($urandom); wdata = 16'($urandom); S = 16'($urandom);
      for (int n = 1; n <= 40; n++) begin
         if (!CE) begin
            ce_n++;
            if (ADDR !== a || UB !== 1'b0 || LB !== 1'b0) bad++;
         end
         if (!WE) begin
            we_n++;
            if (mdata !== d) bad++;
         end
         if (!OE) oe_n++;
         if (!OE && !WE) bad++;
         if (busy !== 1'b1) bad++;
         if (ready === 1'b1) begin
            lat = n; rd = rdata; hx = hex_out;
            break;
         end
         @(negedge Clk);
      end
      @(negedge Clk);
      if (busy !== 1'b0 || ready !== 1'b0) bad++;
   endtask

   task automatic run_vec(input string tag, input logic r, input logic [19:0] a,
                          input logic [15:0] d, input logic [15:0] s, input int exp_lat,
                          input logic [15:0] exp_rd, input logic [15:0] exp_hx);
      int lat, ce_n, we_n, oe_n, bad;
      logic [15:0] rd, hx;
      logic io;
      io = (a == IO);
      xfer(r, a, d, s, lat, rd, hx, ce_n, we_n, oe_n, bad);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " rdata"}, rd, exp_rd);
      chk({tag, " hex_out"}, hx, exp_hx);
      chk({tag, " ce_cycles"}, ce_n, io ? 0 : W);
      chk({tag, " we_cycles"}, we_n, (r && !io) ? W : 0);
      chk({tag, " oe_cycles"}, oe_n, (!r && !io) ? W : 0);
      chk({tag, " protocol"}, bad, 0);
   endtask

   typedef struct {
      logic        r;
      logic [19:0] a;
      logic [15:0] d;
      logic [15:0] s;
      int          lat;
      logic [15:0] rd;
      logic [15:0] hx;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int ready_seen;
      logic [19:0] a;
      logic        r;
      logic [15:0] d, s, exp_rd;

      for (int i = 0; i < 1024; i++) chip[i] = init_val(20'(i));

      tbl[0] = '{1'b1, 20'h00010, 16'hBEEF, 16'h0000, W + 1, 16'h0000, 16'h0000};
      tbl[1] = '{1'b0, 20'h00010, 16'h0000, 16'h0000, W + 1, 16'hBEEF, 16'h0000};
      tbl[2] = '{1'b0, IO,        16'h0000, 16'h1234, 1,     16'h1234, 16'h0000};
      tbl[3] = '{1'b1, IO,        16'h00A5, 16'h0000, 1,     16'h1234, 16'h00A5};
      tbl[4] = '{1'b0, 20'h1FFFF, 16'h0000, 16'h0000, W + 1, 16'h59A5, 16'h00A5};
      tbl[5] = '{1'b1, 20'h1FFFF, 16'h7777, 16'h0000, W + 1, 16'h59A5, 16'h00A5};
      tbl[6] = '{1'b0, 20'h1FFFF, 16'h0000, 16'h0000, W + 1, 16'h7777, 16'h00A5};
      tbl[7] = '{1'b0, 20'h0FFFE, 16'h0000, 16'h0000, W + 1, 16'h59A4, 16'h00A5};
      tbl[8] = '{1'b0, IO,        16'h0000, 16'hABCD, 1,     16'hABCD, 16'h00A5};

      repeat (2) @(negedge Clk);
      chk("reset strobes", {CE, UB, LB, OE, WE}, 5'b11111);
      chk("reset ready", ready, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset ADDR", ADDR, 20'd0);
      chk("reset rdata", rdata, 16'd0);
      chk("reset hex_out", hex_out, 16'd0);
      Reset = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 9; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].s,
                 tbl[i].lat, tbl[i].rd, tbl[i].hx);
         if (tbl[i].r && tbl[i].a != IO) ref_mem[int'(tbl[i].a)] = tbl[i].d;
      end
      ref_rdata = tbl[8].rd;
      ref_hex   = tbl[8].hx;

      // Reset in the first ACCESS cycle of a write aborts it.
      req = 1'b1; rw = 1'b1; addr = 20'h00020; wdata = 16'hCAFE;
      @(posedge Clk);
      @(negedge Clk);
      req = 1'b0;
      chk("abort pre WE", WE, 1'b0);
      #1 Reset = 1'b0;
      #1;
      chk("abort strobes", {CE, UB, LB, OE, WE}, 5'b11111);
      chk("abort busy", busy, 1'b0);
      chk("abort ADDR", ADDR, 20'd0);
      chk("abort rdata", rdata, 16'd0);
      chk("abort hex_out", hex_out, 16'd0);
      ready_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         if (ready === 1'b1) ready_seen++;
      end
      chk("abort no ready", ready_seen, 0);
      Reset = 1'b1;
      ref_rdata = 16'd0;
      ref_hex   = 16'd0;
      run_vec("post-reset rd20", 1'b0, 20'h00020, 16'h0, 16'h0, W + 1, init_val(20'h00020), 16'h0);
      run_vec("post-reset rd10", 1'b0, 20'h00010, 16'h0, 16'h0, W + 1, 16'hBEEF, 16'h0);
      ref_rdata = 16'hBEEF;

      // req held high: one idle cycle between transfers, ready pulses separate.
      req = 1'b1; rw = 1'b0; addr = 20'h00010;
      for (int i = 0; i < 3 * (W + 2); i++) begin
         chk($sformatf("hold busy c%0d", i), busy, 1'((i % (W + 2)) != 0));
         chk($sformatf("hold ready c%0d", i), ready, 1'((i % (W + 2)) == W + 1));
         if (ready === 1'b1) chk("hold rdata", rdata, 16'hBEEF);
         @(negedge Clk);
      end
      req = 1'b0;
      @(negedge Clk);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 5))
            0:       a = IO;
            1:       a = 20'h1FFFF;
            2:       a = 20'h0FFFE;
            default: a = 20'($urandom_range(0, 31));
         endcase
         r = 1'($urandom);
         d = 16'($urandom);
         s = 16'($urandom);
         if (!r) exp_rd = (a == IO) ? s : ref_read(a);
         else    exp_rd = ref_rdata;
         if (r && a == IO) ref_hex = d;
         run_vec($sformatf("rand%0d", t), r, a, d, s, (a == IO) ? 1 : W + 1, exp_rd, ref_hex);
         ref_rdata = exp_rd;
         if (r && a != IO) ref_mem[int'(a)] = d;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
